// File: rtl/matrix_frame_rx.sv
// Serial frame receiver: parses A5/select/data/checksum frames into operand registers
// and answers each complete or rejected frame with an ACK/NAK byte.
module matrix_frame_rx #(
  parameter int WIDTH   = 128,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             new_rx_data,
  output logic [7:0]       tx_data,
  output logic             new_tx_data,
  input  logic             tx_busy,
  output logic [WIDTH-1:0] mat_a,
  output logic [WIDTH-1:0] mat_b,
  output logic             load_a,
  output logic             load_b,
  output logic             frame_err,
  output logic [2:0]       dbg_state
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {IDLE, SEL, DATA, CSUM, SEND} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    byte_cnt;
  logic [7:0]       csum;
  logic [WIDTH-1:0] staging;
  logic             target_b;
  logic [TW-1:0]    idle_cnt;
  logic             in_frame, timed_out, sel_ok, csum_ok, last_data;

  assign dbg_state = state;

  always_comb begin
    in_frame   = (state == SEL) || (state == DATA) || (state == CSUM);
    timed_out  = in_frame && !new_rx_data && (idle_cnt == TW'(TIMEOUT - 1));
    sel_ok     = (rx_data[7:1] == 7'd0);
    csum_ok    = (rx_data == csum);
    last_data  = (byte_cnt == CW'(NBYTES - 1));
    state_next = state;
    unique case (state)
      IDLE: if (new_rx_data && rx_data == HDR) state_next = SEL;
      SEL: begin
        if (new_rx_data)    state_next = sel_ok ? DATA : SEND;
        else if (timed_out) state_next = IDLE;
      end
      DATA: begin
        if (new_rx_data && last_data) state_next = CSUM;
        else if (timed_out)           state_next = IDLE;
      end
      CSUM: begin
        if (new_rx_data)    state_next = SEND;
        else if (timed_out) state_next = IDLE;
      end
      SEND: if (!tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt    <= '0;
      csum        <= '0;
      staging     <= '0;
      target_b    <= 1'b0;
      idle_cnt    <= '0;
      mat_a       <= '0;
      mat_b       <= '0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
      load_a      <= 1'b0;
      load_b      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      new_tx_data <= 1'b0;
      load_a      <= 1'b0;
      load_b      <= 1'b0;
      frame_err   <= 1'b0;
      // Idle counter only runs while a frame is open and no byte arrives.
      if (new_rx_data || !in_frame) idle_cnt <= '0;
      else                          idle_cnt <= idle_cnt + TW'(1);

      if (timed_out) begin
        frame_err <= 1'b1;
        staging   <= '0;
      end

      unique case (state)
        SEL: if (new_rx_data) begin
          if (sel_ok) begin
            byte_cnt <= '0;
            csum     <= rx_data;
            target_b <= rx_data[0];
            staging  <= '0;
          end else begin
            frame_err <= 1'b1;
            tx_data   <= NAK;
          end
        end
        DATA: if (new_rx_data) begin
          staging  <= {staging[WIDTH-9:0], rx_data};
          csum     <= csum ^ rx_data;
          byte_cnt <= byte_cnt + CW'(1);
        end
        CSUM: if (new_rx_data) begin
          if (csum_ok) begin
            if (target_b) begin
              mat_b  <= staging;
              load_b <= 1'b1;
            end else begin
              mat_a  <= staging;
              load_a <= 1'b1;
            end
            tx_data <= ACK;
          end else begin
            frame_err <= 1'b1;
            tx_data   <= NAK;
          end
          staging <= '0;
        end
        SEND: if (!tx_busy) new_tx_data <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_frame_rx.sv
// Directed bench for matrix_frame_rx: drivers push expected loads, errors and response
// bytes into queues; a monitor pops and compares whenever the DUT signals an event.
module tb_matrix_frame_rx;

  localparam int W  = 128;
  localparam int TO = 200;

  logic         clk, rst_n;
  logic [7:0]   rx_data, tx_data;
  logic         new_rx_data, new_tx_data, tx_busy;
  logic [W-1:0] mat_a, mat_b;
  logic         load_a, load_b, frame_err;
  logic [2:0]   dbg_state;

  matrix_frame_rx #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .mat_a(mat_a), .mat_b(mat_b), .load_a(load_a), .load_b(load_b),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] exp_q[$];      // response bytes
  logic [W:0] load_q[$];     // {target_b, value}
  logic [7:0] err_q[$];      // one entry per expected frame_err pulse
  logic [W-1:0] sh_a = '0, sh_b = '0;

  localparam logic [W-1:0] V1 = 128'h00000001_00000002_00000003_00000004;
  localparam logic [W-1:0] V2 = 128'hFFFFFFFF_80000000_7FFFFFFF_00000000;
  localparam logic [W-1:0] V3 = 128'h11121314_15161718_191A1B1C_1D1E1F20;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (dbg_state != 3'd0 && n < 50);
    check("wait_idle", {126'd0, dbg_state}, 129'd0);
  endtask

  // Full frame; bad flips the checksum; busy>0 holds tx_busy that many cycles
  // from the checksum byte and sends a stray 0xA5 while the response is pending.
  task automatic send_frame(input logic [7:0] sel, input logic [W-1:0] data,
                            input bit bad, input int busy);
    logic [7:0] cs;
    cs = sel;
    send_byte(8'hA5);
    send_byte(sel);
    for (int i = 0; i < W / 8; i++) begin
      send_byte(data[W-1-8*i -: 8]);
      cs = cs ^ data[W-1-8*i -: 8];
    end
    if (bad) begin
      cs = cs ^ 8'h01;
      err_q.push_back(8'h02);
      exp_q.push_back(8'h15);
    end else begin
      load_q.push_back({sel[0], data});
      exp_q.push_back(8'h06);
    end
    @(negedge clk);
    rx_data = cs;
    new_rx_data = 1'b1;
    if (busy > 0) tx_busy = 1'b1;
    @(posedge clk); #1;
    check(sel[0] ? "load_b_latency" : "load_a_latency",
          {128'd0, sel[0] ? load_b : load_a}, {128'd0, !bad});
    @(negedge clk);
    new_rx_data = 1'b0;
    if (busy > 0) begin
      rx_data = 8'hA5;
      new_rx_data = 1'b1;
      @(negedge clk);
      new_rx_data = 1'b0;
      repeat (busy - 2) @(negedge clk);
      tx_busy = 1'b0;
      @(posedge clk); #1;
      check("strobe_after_busy", {128'd0, new_tx_data}, 129'd1);
      check("tx_after_busy", {121'd0, tx_data}, 129'h06);
    end
    wait_idle();
  endtask

  // scoreboard monitor
  always begin
    logic [W:0] e;
    @(posedge clk); #1;
    if (!rst_n) begin
      sh_a = '0;
      sh_b = '0;
    end else begin
      if (frame_err || load_a || load_b)
        check("event_exclusive", {126'd0, 2'(frame_err) + 2'(load_a) + 2'(load_b)}, 129'd1);
      if (load_a || load_b) begin
        if (load_q.size() == 0) check("unexpected_load", {127'd0, load_b, load_a}, 129'd0);
        else begin
          e = load_q.pop_front();
          if (e[W]) sh_b = e[W-1:0];
          else      sh_a = e[W-1:0];
          check("load_target", {128'd0, load_b}, {128'd0, e[W]});
        end
      end
      check("mat_a", {1'b0, mat_a}, {1'b0, sh_a});
      check("mat_b", {1'b0, mat_b}, {1'b0, sh_b});
      if (frame_err) begin
        if (err_q.size() == 0) check("unexpected_frame_err", 129'd1, 129'd0);
        else void'(err_q.pop_front());
      end
      if (dbg_state == 3'd4) begin
        if (exp_q.size() == 0) check("send_without_expect", 129'd1, 129'd0);
        else check("tx_hold", {121'd0, tx_data}, {121'd0, exp_q[0]});
      end
      if (new_tx_data) begin
        check("strobe_while_busy", {128'd0, tx_busy}, 129'd0);
        if (exp_q.size() == 0) check("unexpected_tx", {121'd0, tx_data}, 129'h1FF);
        else check("tx_data", {121'd0, tx_data}, {121'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mat_a"}, {1'b0, mat_a}, 129'd0);
    check({tag, "_mat_b"}, {1'b0, mat_b}, 129'd0);
    check({tag, "_ctl"}, {123'd0, load_a, load_b, frame_err, new_tx_data, dbg_state != 3'd0, 1'b0},
          129'd0);
    check({tag, "_tx_data"}, {121'd0, tx_data}, 129'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    new_rx_data = 1'b0;
    tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    send_frame(8'h00, V1, 1'b0, 0);          // good frame to A
    send_frame(8'h00, V1, 1'b1, 0);          // checksum error
    send_byte(8'h55);                        // junk before header
    send_frame(8'h01, V1, 1'b0, 0);          // good frame to B

    err_q.push_back(8'h01);                  // invalid select
    exp_q.push_back(8'h15);
    send_byte(8'hA5);
    send_byte(8'h02);
    wait_idle();

    send_byte(8'hA5);                        // partial frame then timeout
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(V2[W-1-8*i -: 8]);
    err_q.push_back(8'h03);
    repeat (TO + 10) @(negedge clk);
    check("timeout_idle", {126'd0, dbg_state}, 129'd0);
    send_frame(8'h00, V2, 1'b0, 0);

    send_frame(8'h01, V3, 1'b0, 10);         // response held off by tx_busy
    send_byte(8'h00);                        // headerless: must be ignored
    for (int i = 0; i < W / 8; i++) send_byte(V1[W-1-8*i -: 8]);
    send_byte(8'h04);
    repeat (3) @(negedge clk);
    check("headerless_idle", {126'd0, dbg_state}, 129'd0);

    send_byte(8'hA5);                        // reset mid-frame
    send_byte(8'h01);
    for (int i = 0; i < 8; i++) send_byte(V1[W-1-8*i -: 8]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h00, V1, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("exp_q_drained", 129'(exp_q.size()), 129'd0);
    check("load_q_drained", 129'(load_q.size()), 129'd0);
    check("err_q_drained", 129'(err_q.size()), 129'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/matrix_frame_rx.md
MATRIX_FRAME_RX -- requirements
Module: matrix_frame_rx

Interface
REQ-001 Parameter: WIDTH, 128, operand width in bits; SHALL be a multiple of 8.
REQ-002 Parameter: TIMEOUT, 50000, inter-byte timeout in clk cycles (1 ms at 50 MHz).
REQ-003 clk  input  1  50 MHz system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_data  input  8  received byte from AVR serial interface.
REQ-006 new_rx_data  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-007 tx_data  output  8  response byte to AVR serial interface.
REQ-008 new_tx_data  output  1  one-cycle strobe; tx_data to be sent.
REQ-009 tx_busy  input  1  transmitter busy; no strobe allowed while high.
REQ-010 mat_a  output  WIDTH  operand A register, signed, 4 x 32-bit elements.
REQ-011 mat_b  output  WIDTH  operand B register, signed, 4 x 32-bit elements.
REQ-012 load_a / load_b  output  1 each  one-cycle pulse when mat_a / mat_b updated.
REQ-013 frame_err  output  1  one-cycle pulse on any rejected frame.

Function
REQ-014 Frame SHALL be: header 0xA5, select byte, WIDTH/8 data bytes, checksum byte.
REQ-015 Select 0x00 SHALL target mat_a, 0x01 mat_b; any other value is a select error.
REQ-016 Checksum SHALL be XOR of select byte and all data bytes.
REQ-017 First data byte SHALL land in bits [WIDTH-1:WIDTH-8], MSB-first, big-endian per element.
REQ-018 States: IDLE, SEL, DATA, CSUM, SEND; only bytes with new_rx_data=1 advance parsing.
REQ-019 IDLE: byte 0xA5 -> SEL; any other byte ignored, no error.
REQ-020 SEL: valid select -> DATA, byte counter=0, checksum accumulator=select; invalid -> frame_err pulse, NAK (0x15), SEND.
REQ-021 DATA: each byte shifts into staging register, XORs into accumulator; after byte WIDTH/8 -> CSUM.
REQ-022 CSUM: match -> target register = staging, load pulse, ACK (0x06), SEND; mismatch -> frame_err pulse, NAK, SEND, targets unchanged.
REQ-023 Checksum byte strobe at cycle N -> mat_x and load_x updated/pulsed at N+1.
REQ-024 SEND: new_tx_data SHALL pulse exactly once, in the first cycle with tx_busy=0, earliest N+2; then IDLE.
REQ-025 tx_data SHALL hold the response byte from SEND entry until the strobe cycle inclusive.
REQ-026 Bytes arriving in SEND SHALL be dropped, including 0xA5.
REQ-027 Timeout counter SHALL clear on each accepted byte; in SEL/DATA/CSUM, reaching TIMEOUT cycles -> frame_err pulse, IDLE, no response byte, staging discarded.
REQ-028 Non-targeted register SHALL never change; partial frames SHALL never modify mat_a/mat_b.
REQ-029 frame_err, load_a, load_b SHALL never assert in the same cycle.

Reset
REQ-030 rst_n=0 SHALL immediately force: state IDLE, mat_a=mat_b=0, tx_data=0x00, new_tx_data=load_a=load_b=frame_err=0, counters and staging 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; first frame after release SHALL parse normally.

Verification
REQ-032 A5 00 {00 00 00 01 00 00 00 02 00 00 00 03 00 00 00 04} 04 -> mat_a=0x00000001_00000002_00000003_00000004, load_a one pulse, tx 0x06 once, mat_b=0.
REQ-033 Same frame with checksum 0x05 -> frame_err pulse, tx 0x15, mat_a unchanged, no load_a.
REQ-034 55 A5 01 {same 16 bytes} 05 -> leading 0x55 ignored, mat_b updated, load_b pulse, tx 0x06.
REQ-035 A5 02 -> frame_err pulse at select, tx 0x15; A5 00 + 5 data bytes then idle TIMEOUT cycles -> frame_err, no tx byte, a following valid frame accepted.
REQ-036 tx_busy held high 10 cycles after valid checksum -> new_tx_data single pulse in first cycle tx_busy=0, tx_data=0x06 stable throughout.
REQ-037 rst_n low 3 cycles after 8th data byte -> all outputs 0 asynchronously; subsequent full valid frame loads correctly.
